powlib_sfifo: RTL and testbench
===============================

// Module: powlib_sfifo
// PURPOSE
//   Synchronous FIFO with valid/ready handshakes on both sides.
//   - Buffers words between a producer and a powlib_flipflop pipeline stage.
//   - Absorbs backpressure that the flipflop stage (vld only, no ready) cannot express.
//   - Output is first-word-fall-through (FWFT): the head word is presented on rddata whenever rdvld=1.
// PARAMETERS
//   W     8   data width in bits
//   D     8   depth in words; power of two, D>=2
//   INIT  0   W-bit value driven on rddata after reset until the first word is written
// PORTS
//   clk     in   1         clock; all logic on rising edge
//   rst     in   1         reset, synchronous, active-high
//   wrdata  in   W         write data
//   wrvld   in   1         write valid
//   wrrdy   out  1         write ready; a transfer occurs when wrvld & wrrdy
//   rddata  out  W         head-of-queue data
//   rdvld   out  1         read valid (FIFO not empty)
//   rdrdy   in   1         read ready; a pop occurs when rdvld & rdrdy
//   cnt     out  $clog2(D)+1  occupancy; present only with POWLIB_SFIFO_CNT_EN
// BEHAVIOUR
//   - Reset (rst=1 at an edge):
//     - Pointers and occupancy clear to 0; rdvld=0; rddata=INIT.
//     - wrrdy is forced to 0 while rst=1 (combinational gate) and returns to 1 the cycle after rst deasserts.
//     - Storage array is not reset.
//   - Reset mid-operation discards all contents; any push or pop presented in the rst cycle is ignored.
//   - Pointers: wptr and rptr are $clog2(D)+1 bits wide.
//     - The extra MSB distinguishes full from empty.
//     - Pointers wrap modulo 2*D with no special-case logic.
//   - Empty: wptr==rptr.
//   - Full: the pointer MSBs differ and the low bits are equal.
//   - wrrdy = !full & !rst. rdvld = !empty.
//   - Push: mem[wptr low bits] <= wrdata; wptr++.
//   - Pop: rptr++.
//   - Latency: a word written at edge N is visible on rddata with rdvld=1 after edge N (1 cycle), including when the FIFO was empty.
//   - Push and pop in the same cycle: both take effect; occupancy is unchanged.
//     - This is legal when partially full, including occupancy 1.
//   - When full: wrrdy=0, so a simultaneous pop does not enable a same-cycle push; the write is accepted next cycle.
//   - When empty: rdrdy is ignored; rddata holds the last popped word (INIT if none).
//   - rddata is registered (read-ahead register), not a combinational RAM read.
//   - Overflow and underflow are impossible by construction; no error outputs.
// CONFIGURATION
//   POWLIB_SFIFO_CNT_EN
//     - Defined: the cnt port exists and reports occupancy 0..D, updated on the same edge as the pointers; reset value 0.
//     - Undefined: no cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//   - Package powlib_pkg:
//     - powlib_clog2 function.
//     - Pointer-width localparam helper PW(D) = powlib_clog2(D)+1.
//   - One sub-module, powlib_sfifo_mem: simple dual-port RAM, D x W, 1 write port, 1 registered read port, no reset.
//   - Top level holds the pointers, full/empty logic, read-ahead control and the optional counter.
// TESTING
//   - Reset: rst=1 for 2 cycles -> wrrdy=0 during reset; then wrrdy=1, rdvld=0, rddata=INIT (W=8, INIT=8'hA5 -> 8'hA5).
//   - Fill and drain: push 0x01..0x08 with rdrdy=0.
//     - Expect wrrdy=0 after the 8th push; cnt=8.
//     - Pop all with rdrdy=1 -> 0x01..0x08 in order, then rdvld=0.
//   - Empty write latency: write 0x3C at edge N -> rdvld=1 and rddata=0x3C after edge N.
//   - Simultaneous push/pop at occupancy 1 and at occupancy 7: occupancy unchanged; order preserved across pointer wrap (>=3*D words streamed).
//   - Full plus pop: FIFO full, wrvld=1, rdrdy=1 -> pop in cycle N; push accepted in N+1; cnt 8->7->8.
//   - Reset mid-stream: 5 words stored, rst=1 -> next cycle rdvld=0, cnt=0, rddata=INIT; old data never reappears.

Source files
------------

// File: rtl/powlib_pkg.sv
// powlib_pkg: shared sizing helpers for the powlib blocks.
package powlib_pkg;

    function automatic int powlib_clog2(input int n);
        int r;
        r = 0;
        for (int i = 1; i < n; i = i * 2) r++;
        return r;
    endfunction

    // Pointer width with one extra wrap bit to tell full from empty.
    function automatic int powlib_pw(input int d);
        return powlib_clog2(d) + 1;
    endfunction

endpackage

// File: rtl/powlib_sfifo_mem.sv
// powlib_sfifo_mem: D x W simple dual-port RAM with a registered read port and no reset.
module powlib_sfifo_mem
    import powlib_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [powlib_clog2(D)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [powlib_clog2(D)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem_q [D];
    logic [W-1:0] rdata_q;

    // Write-first bypass so a word pushed into an empty queue is readable one edge later.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        if (re) rdata_q <= (we && waddr == raddr) ? wdata : mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/powlib_sfifo.sv
// powlib_sfifo: FWFT synchronous FIFO with valid/ready on both sides.
// Optional occupancy port cnt is built when POWLIB_SFIFO_CNT_EN is defined.
module powlib_sfifo
    import powlib_pkg::*;
#(
    parameter int           W    = 8,
    parameter int           D    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W-1:0]            wrdata,
    input  logic                    wrvld,
    output logic                    wrrdy,
    output logic [W-1:0]            rddata,
    output logic                    rdvld,
    input  logic                    rdrdy
`ifdef POWLIB_SFIFO_CNT_EN
    ,
    output logic [powlib_clog2(D):0] cnt
`endif
);
    localparam int PW = powlib_pw(D);
    localparam int AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          init_q, init_d;
    logic          full, empty, push, pop, ren;
    logic [AW-1:0] raddr;
    logic [W-1:0]  mem_rdata;
`ifdef POWLIB_SFIFO_CNT_EN
    logic [PW-1:0] cnt_q, cnt_d;
`endif

    // The read-ahead register reloads whenever the head changes: a pop, or a push into an empty queue.
    always_comb begin
        empty  = wptr_q == rptr_q;
        full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        wrrdy  = !full && !rst;
        rdvld  = !empty;
        push   = wrvld && wrrdy;
        pop    = rdvld && rdrdy && !rst;
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        ren    = (pop || empty) && (wptr_d != rptr_d) && !rst;
        raddr  = rptr_d[AW-1:0];
        init_d = init_q && !ren;
        rddata = init_q ? INIT : mem_rdata;
`ifdef POWLIB_SFIFO_CNT_EN
        cnt_d  = cnt_q + PW'(push) - PW'(pop);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            init_q <= 1'b1;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            init_q <= init_d;
        end
    end

`ifdef POWLIB_SFIFO_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
`endif

    powlib_sfifo_mem #(.W(W), .D(D)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q[AW-1:0]),
        .wdata (wrdata),
        .re    (ren),
        .raddr (raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_powlib_sfifo.sv
// tb_powlib_sfifo: directed vector table, corner sequences and random traffic against a queue model.
module tb_powlib_sfifo;
    localparam int         W    = 8;
    localparam int         D    = 8;
    localparam logic [7:0] INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, wrvld, rdrdy, wrrdy, rdvld;
    logic [7:0] wrdata, rddata;
`ifdef POWLIB_SFIFO_CNT_EN
    logic [3:0] cnt;
`endif

    always #5 clk = ~clk;

    powlib_sfifo #(.W(W), .D(D), .INIT(INIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .wrdata (wrdata),
        .wrvld  (wrvld),
        .wrrdy  (wrrdy),
        .rddata (rddata),
        .rdvld  (rdvld),
        .rdrdy  (rdrdy)
`ifdef POWLIB_SFIFO_CNT_EN
        ,
        .cnt    (cnt)
`endif
    );

    typedef struct {
        logic       r;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       ev;
        logic [7:0] ed;
        logic       er;
    } vec_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] q[$];
    logic [7:0] last = INIT;
    vec_t       tv[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, check wrrdy before the edge, advance the model, check outputs after.
    task automatic cyc(input logic r, input logic wv, input logic [7:0] wd, input logic rr);
        logic pu, po;
        rst = r; wrvld = wv; wrdata = wd; rdrdy = rr;
        #1;
        chk("wrrdy_pre", wrrdy, !r && q.size() < D);
        po = !r && rr && q.size() > 0;
        pu = !r && wv && q.size() < D;
        @(posedge clk);
        if (r) begin
            q.delete();
            last = INIT;
        end else begin
            if (po) last = q.pop_front();
            if (pu) q.push_back(wd);
        end
        #1;
        chk("rdvld", rdvld, q.size() > 0);
        chk("rddata", rddata, q.size() > 0 ? q[0] : last);
`ifdef POWLIB_SFIFO_CNT_EN
        chk("cnt", cnt, q.size());
`endif
    endtask

    initial begin
        rst = 1'b1; wrvld = 1'b0; wrdata = '0; rdrdy = 1'b0;
        tv.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, INIT, 1'b0});
        tv.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, INIT, 1'b0});
        tv.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, INIT, 1'b1});
        for (int k = 1; k <= 8; k++)
            tv.push_back('{1'b0, 1'b1, 8'(k), 1'b0, 1'b1, 8'h01, k < 8});
        for (int k = 1; k <= 8; k++)
            tv.push_back('{1'b0, 1'b0, 8'h00, 1'b1, k < 8, k < 8 ? 8'(k + 1) : 8'h08, 1'b1});
        tv.push_back('{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1});
        tv.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1});

        foreach (tv[i]) begin
            cyc(tv[i].r, tv[i].wv, tv[i].wd, tv[i].rr);
            chk("tbl_vld", rdvld, tv[i].ev);
            chk("tbl_data", rddata, tv[i].ed);
            chk("tbl_rdy", wrrdy, tv[i].er);
        end

        // Simultaneous push/pop at occupancy 1 then 7.
        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h22, 1);
        chk("occ1_data", rddata, 8'h22);
        for (int k = 0; k < 6; k++) cyc(0, 1, 8'(8'h30 + k), 0);
        cyc(0, 1, 8'h40, 1);
        chk("occ7_data", rddata, 8'h30);
        chk("occ7_rdy", wrrdy, 1'b1);

        // Full plus pop: pop in cycle N, push lands in N+1.
        cyc(0, 1, 8'h41, 0);
        chk("full_rdy", wrrdy, 1'b0);
        cyc(0, 1, 8'hAA, 1);
        chk("fullpop_rdy", wrrdy, 1'b1);
`ifdef POWLIB_SFIFO_CNT_EN
        chk("fullpop_cnt7", cnt, 4'd7);
`endif
        cyc(0, 1, 8'hAA, 0);
        chk("refill_rdy", wrrdy, 1'b0);
`ifdef POWLIB_SFIFO_CNT_EN
        chk("refill_cnt8", cnt, 4'd8);
`endif

        // Stream well past pointer wrap at partial occupancy.
        for (int k = 0; k < 4; k++) cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 30; k++) cyc(0, 1, 8'($urandom), 1);

        // Reset mid-stream with 5 words stored; push/pop in the reset cycle are ignored.
        for (int k = 0; k < D; k++) cyc(0, 0, 8'h00, 1);
        for (int k = 0; k < 5; k++) cyc(0, 1, 8'(8'h50 + k), 0);
        cyc(1, 1, 8'h77, 1);
        chk("rst_vld", rdvld, 1'b0);
        chk("rst_data", rddata, INIT);
        cyc(0, 0, 8'h00, 1);
        chk("post_rst_vld", rdvld, 1'b0);
        chk("post_rst_data", rddata, INIT);

        for (int k = 0; k < 800; k++)
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
